// File: rtl/mux21_pkg.sv
// rtl/mux21_pkg.sv - shared state encoding and sizing for the 2:1 TDM receiver
package mux21_pkg;

   localparam int DEFAULT_W = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Bit counter spans both channels of a frame: 0..2W-1.
   function automatic int cnt_width(input int w);
      return $clog2(2 * w);
   endfunction

endpackage

// File: rtl/mux21.sv
// rtl/mux21.sv - gate-level 2:1 multiplexer that serialises the two channels onto Y
module mux21 (
   input  logic D0,
   input  logic D1,
   input  logic S,
   output logic Y
);

   logic w_sn;
   logic w_a0;
   logic w_a1;

   not u_not (w_sn, S);
   and u_and0 (w_a0, D0, w_sn);
   and u_and1 (w_a1, D1, S);
   or  u_or (Y, w_a0, w_a1);

endmodule

// File: rtl/tdm_shreg.sv
// rtl/tdm_shreg.sv - W-bit MSB-first serial-in shift register with shift enable
module tdm_shreg
   import mux21_pkg::*;
#(
   parameter int W = DEFAULT_W
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_shift,
   input  logic         i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_sr;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sr <= '0;
      end else if (i_shift) begin
         r_sr <= {r_sr[W-2:0], i_d};
      end
   end

   assign o_q = r_sr;

endmodule

// File: rtl/mux21_tdm_rx.sv
// rtl/mux21_tdm_rx.sv - drives the 2:1 mux select and deserialises Y into two channel words
module mux21_tdm_rx
   import mux21_pkg::*;
#(
   parameter int W = DEFAULT_W
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         EN,
   input  logic         Y,
   output logic         S,
   output logic [W-1:0] Q0,
   output logic [W-1:0] Q1,
   output logic         VALID,
   input  logic         READY,
   output logic         OVF
);

   localparam int             CW   = cnt_width(W);
   localparam logic [CW-1:0]  LAST = CW'(2 * W - 1);

   state_t        r_state;
   state_t        w_state_next;
   logic          w_step;
   logic          r_s;
   logic [CW-1:0] r_cnt;
   logic [W-1:0]  w_sr0_q;
   logic [W-1:0]  w_sr1_q;
   logic          w_frame_done;
   logic [W-1:0]  r_q0;
   logic [W-1:0]  r_q1;
   logic          r_valid;
   logic          r_ovf;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // The edge that leaves IDLE already samples bit 0, so a frame takes exactly 2W enabled edges.
   always_comb begin
      w_state_next = r_state;
      w_step       = 1'b0;
      case (r_state)
         IDLE: begin
            if (EN) begin
               w_state_next = RUN;
               w_step       = 1'b1;
            end
         end
         RUN: begin
            w_step = EN;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_s   <= 1'b0;
         r_cnt <= '0;
      end else if (w_step) begin
         r_s   <= ~r_s;
         r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
      end
   end

   tdm_shreg #(.W(W)) u_sr0 (
      .i_clk   (CLK),
      .i_rst   (RST),
      .i_shift (w_step & ~r_s),
      .i_d     (Y),
      .o_q     (w_sr0_q)
   );

   tdm_shreg #(.W(W)) u_sr1 (
      .i_clk   (CLK),
      .i_rst   (RST),
      .i_shift (w_step & r_s),
      .i_d     (Y),
      .o_q     (w_sr1_q)
   );

   assign w_frame_done = w_step && (r_cnt == LAST);

   // Channel 1's last bit arrives on the completion edge, so it is spliced in here.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_q0    <= '0;
         r_q1    <= '0;
         r_valid <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (w_frame_done) begin
         if (!r_valid || READY) begin
            r_q0    <= w_sr0_q;
            r_q1    <= {w_sr1_q[W-2:0], Y};
            r_valid <= 1'b1;
         end else begin
            r_ovf <= 1'b1;
         end
      end else if (r_valid && READY) begin
         r_valid <= 1'b0;
      end
   end

   assign S     = r_s;
   assign Q0    = r_q0;
   assign Q1    = r_q1;
   assign VALID = r_valid;
   assign OVF   = r_ovf;

endmodule

// File: tb/tb_mux21_tdm_rx.sv
// tb/tb_mux21_tdm_rx.sv - directed self-checking bench with the mux21 closing the S->Y loop
module tb_mux21_tdm_rx;

   logic       CLK = 1'b0;
   logic       RST;
   logic       EN;
   logic       READY;
   logic       D0;
   logic       D1;
   logic       Y;
   logic       S;
   logic [7:0] Q0;
   logic [7:0] Q1;
   logic       VALID;
   logic       OVF;

   int tests = 0;
   int fails = 0;

   always #5 CLK = ~CLK;

   mux21 u_mux (
      .D0 (D0),
      .D1 (D1),
      .S  (S),
      .Y  (Y)
   );

   mux21_tdm_rx #(.W(8)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .EN    (EN),
      .Y     (Y),
      .S     (S),
      .Q0    (Q0),
      .Q1    (Q1),
      .VALID (VALID),
      .READY (READY),
      .OVF   (OVF)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic en, input logic d0, input logic d1, input logic rdy);
      EN    = en;
      D0    = d0;
      D1    = d1;
      READY = rdy;
      @(posedge CLK);
      #1;
   endtask

   task automatic pause(input logic rdy);
      logic r0;
      logic r1;
      r0 = 1'($urandom_range(1, 0));
      r1 = 1'($urandom_range(1, 0));
      step(1'b0, r0, r1, rdy);
   endtask

   // Enabled edge k carries bit (7 - k/2) of each channel word.
   task automatic send(input logic [7:0] a, input logic [7:0] b, input int k0, input int k1,
                       input logic rdy_mid, input logic rdy_last);
      for (int k = k0; k <= k1; k++) begin
         step(1'b1, a[7 - k/2], b[7 - k/2], (k == 15) ? rdy_last : rdy_mid);
      end
   endtask

   task automatic do_reset();
      RST = 1'b1;
      step(1'b0, 1'b0, 1'b0, 1'b0);
      RST = 1'b0;
   endtask

   initial begin
      RST = 1'b1; EN = 1'b0; READY = 1'b0; D0 = 1'b0; D1 = 1'b0;
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check("rst_s", 16'(S), 16'h0);
      check("rst_q0", 16'(Q0), 16'h0);
      check("rst_q1", 16'(Q1), 16'h0);
      check("rst_valid", 16'(VALID), 16'h0);
      check("rst_ovf", 16'(OVF), 16'h0);
      RST = 1'b0;

      // Basic frame with consumer always ready
      send(8'hA5, 8'h3C, 0, 14, 1'b1, 1'b1);
      check("a_valid_before_last", 16'(VALID), 16'h0);
      send(8'hA5, 8'h3C, 15, 15, 1'b1, 1'b1);
      check("a_valid", 16'(VALID), 16'h1);
      check("a_q0", 16'(Q0), 16'hA5);
      check("a_q1", 16'(Q1), 16'h3C);
      check("a_ovf", 16'(OVF), 16'h0);
      check("a_s_wrapped", 16'(S), 16'h0);
      pause(1'b1);
      check("a_valid_consumed", 16'(VALID), 16'h0);
      check("a_q0_kept", 16'(Q0), 16'hA5);

      // Load and consume on the same completion edge
      send(8'h11, 8'h22, 0, 15, 1'b0, 1'b0);
      check("b_q0_f1", 16'(Q0), 16'h11);
      check("b_q1_f1", 16'(Q1), 16'h22);
      send(8'h96, 8'h69, 0, 15, 1'b0, 1'b1);
      check("b_valid", 16'(VALID), 16'h1);
      check("b_q0_f2", 16'(Q0), 16'h96);
      check("b_q1_f2", 16'(Q1), 16'h69);
      check("b_ovf", 16'(OVF), 16'h0);

      // Overflow with consumer stalled across two frames
      do_reset();
      send(8'hA5, 8'h3C, 0, 15, 1'b0, 1'b0);
      check("c_valid_f1", 16'(VALID), 16'h1);
      check("c_ovf_f1", 16'(OVF), 16'h0);
      send(8'hFF, 8'h00, 0, 15, 1'b0, 1'b0);
      check("c_q0", 16'(Q0), 16'hA5);
      check("c_q1", 16'(Q1), 16'h3C);
      check("c_ovf", 16'(OVF), 16'h1);
      check("c_valid", 16'(VALID), 16'h1);
      pause(1'b1);
      check("c_valid_consumed", 16'(VALID), 16'h0);
      check("c_ovf_sticky", 16'(OVF), 16'h1);

      // EN pauses mid-frame with garbage on the line
      do_reset();
      send(8'hA5, 8'h3C, 0, 7, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         pause(1'b1);
         check("d_s_frozen0", 16'(S), 16'h0);
      end
      send(8'hA5, 8'h3C, 8, 10, 1'b1, 1'b1);
      for (int i = 0; i < 2; i++) begin
         pause(1'b1);
         check("d_s_frozen1", 16'(S), 16'h1);
      end
      check("d_valid_mid", 16'(VALID), 16'h0);
      send(8'hA5, 8'h3C, 11, 15, 1'b1, 1'b1);
      check("d_valid", 16'(VALID), 16'h1);
      check("d_q0", 16'(Q0), 16'hA5);
      check("d_q1", 16'(Q1), 16'h3C);

      // Asynchronous reset mid-frame, release with EN low
      do_reset();
      send(8'hA5, 8'h3C, 0, 15, 1'b0, 1'b0);
      send(8'hFF, 8'h00, 0, 15, 1'b0, 1'b0);
      send(8'h77, 8'h88, 0, 8, 1'b0, 1'b0);
      check("e_s_pre", 16'(S), 16'h1);
      check("e_ovf_pre", 16'(OVF), 16'h1);
      EN = 1'b0;
      #2;
      RST = 1'b1;
      #1;
      check("e_rst_s", 16'(S), 16'h0);
      check("e_rst_q0", 16'(Q0), 16'h0);
      check("e_rst_q1", 16'(Q1), 16'h0);
      check("e_rst_valid", 16'(VALID), 16'h0);
      check("e_rst_ovf", 16'(OVF), 16'h0);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      pause(1'b0);
      pause(1'b0);
      check("e_idle_s", 16'(S), 16'h0);
      send(8'h5A, 8'hC3, 0, 15, 1'b1, 1'b1);
      check("e_valid", 16'(VALID), 16'h1);
      check("e_q0", 16'(Q0), 16'h5A);
      check("e_q1", 16'(Q1), 16'hC3);
      check("e_ovf", 16'(OVF), 16'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
